// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per clock, registered carry between chunks.
// Optional signed-overflow output enabled by defining ADDER_OVF_EN.
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $fatal(1, "serial_chunk_adder: illegal WIDTH/CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   csum;
  logic             last;

  // Chunk slice of the latched operands and its ripple sum with the carry
  always_comb begin
    base    = 32'(cnt_q) * 32'(CHUNK);
    a_chunk = a_q[base +: CHUNK];
    b_chunk = b_q[base +: CHUNK];
    csum    = {1'b0, a_chunk} + {1'b0, b_chunk}
            + (CHUNK+1)'(carry_q);
    last    = (cnt_q == CW'(NCHUNK - 1));
  end

  // Next-state and registered-output logic for the IDLE/BUSY/DONE sequence
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    co_d        = co_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          carry_d    = ci;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        acc_d[base +: CHUNK] = csum[CHUNK-1:0];
        carry_d = csum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          sum_d       = acc_d;
          co_d        = csum[CHUNK];
          ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1])
                     && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      co_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      co_q        <= co_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign co        = co_q;

`ifdef ADDER_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder (16/4 plus exhaustive 4/1 and 4/4).
// Checks ovf as well when ADDER_OVF_EN is defined.
module tb_serial_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv0 = 1'b0, ir0, ov0, ordy0 = 1'b1, ci0 = 1'b0, co0;
  logic [15:0] a0 = '0, b0 = '0, sum0;

  logic        iv_s = 1'b0, ci_s = 1'b0, ordy_s = 1'b0;
  logic [3:0]  a_s = '0, b_s = '0;
  logic        ir1, ov1, co1, ir2, ov2, co2;
  logic [3:0]  sum1, sum2;
`ifdef ADDER_OVF_EN
  logic        ovf0, ovf1, ovf2;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv0), .in_ready(ir0),
    .a(a0), .b(b0), .ci(ci0),
    .out_valid(ov0), .out_ready(ordy0),
    .sum(sum0), .co(co0)
`ifdef ADDER_OVF_EN
    , .ovf(ovf0)
`endif
  );

  serial_chunk_adder #(.WIDTH(4), .CHUNK(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_s), .in_ready(ir1),
    .a(a_s), .b(b_s), .ci(ci_s),
    .out_valid(ov1), .out_ready(ordy_s),
    .sum(sum1), .co(co1)
`ifdef ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  serial_chunk_adder #(.WIDTH(4), .CHUNK(4)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_s), .in_ready(ir2),
    .a(a_s), .b(b_s), .ci(ci_s),
    .out_valid(ov2), .out_ready(ordy_s),
    .sum(sum2), .co(co2)
`ifdef ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] ta,
                       input logic [15:0] tb, input logic tci,
                       input logic [15:0] es, input logic eco);
    int n;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(ir0), 32'd1);
    a0 = ta; b0 = tb; ci0 = tci; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    n = 0;
    while (!ov0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'd4);
    chk({tag, ".sum"}, 32'(sum0), 32'(es));
    chk({tag, ".co"}, 32'(co0), 32'(eco));
  endtask

  initial begin
    int n;
    logic saw;
    logic [4:0] exp5;

    @(negedge clk);
    chk("rst.in_ready", 32'(ir0), 32'd1);
    chk("rst.out_valid", 32'(ov0), 32'd0);
    chk("rst.sum", 32'(sum0), 32'd0);
    chk("rst.co", 32'(co0), 32'd0);
    rst_n = 1'b1;

    do_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    chk("wrap.pulse", 32'(ov0), 32'd0);
    chk("wrap.ready", 32'(ir0), 32'd1);

    ordy0 = 1'b0;
    do_op("carry", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst.in_ready", 32'(ir0), 32'd1);
    chk("arst.out_valid", 32'(ov0), 32'd0);
    chk("arst.sum", 32'(sum0), 32'd0);
    chk("arst.co", 32'(co0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("bp", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    for (int i = 0; i < 10; i++) begin
      iv0 = (i % 2 == 0);
      a0 = 16'hAAAA; b0 = 16'hAAAA; ci0 = 1'b1;
      @(negedge clk);
      chk("bp.out_valid", 32'(ov0), 32'd1);
      chk("bp.sum", 32'(sum0), 32'h5555);
      chk("bp.co", 32'(co0), 32'd0);
      chk("bp.in_ready", 32'(ir0), 32'd0);
    end
    iv0 = 1'b0;
    ordy0 = 1'b1;
    @(negedge clk);
    chk("bp.release_ov", 32'(ov0), 32'd0);
    chk("bp.release_ir", 32'(ir0), 32'd1);
    do_op("post", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);

    @(negedge clk);
    a0 = 16'h1111; b0 = 16'h2222; ci0 = 1'b0; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    saw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      saw = saw | ov0;
    end
    chk("midrst.no_result", 32'(saw), 32'd0);
    do_op("midrst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);

`ifdef ADDER_OVF_EN
    do_op("ovf1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    chk("ovf1.ovf", 32'(ovf0), 32'd1);
    do_op("ovf2", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    chk("ovf2.ovf", 32'(ovf0), 32'd1);
    do_op("ovf3", 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    chk("ovf3.ovf", 32'(ovf0), 32'd0);
`endif

    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      chk($sformatf("ex%0d.ready", k), 32'(ir1 & ir2), 32'd1);
      a_s = 4'(k);
      b_s = 4'(k >> 4);
      ci_s = k[8];
      iv_s = 1'b1;
      exp5 = 5'(a_s) + 5'(b_s) + 5'(ci_s);
      @(negedge clk);
      iv_s = 1'b0;
      n = 0;
      while (!(ov1 && ov2) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("ex%0d.c1", k), 32'({co1, sum1}), 32'(exp5));
      chk($sformatf("ex%0d.c4", k), 32'({co2, sum2}), 32'(exp5));
      ordy_s = 1'b1;
      @(negedge clk);
      ordy_s = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
Multi-cycle parametrised adder: successor to the single-bit full adder for wide operands where a full-width carry chain is too slow or too large. Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, with a registered carry between chunks. Uses valid/ready handshakes on both input and output so it can sit between pipeline stages of the arithmetic datapath.

Parameters:
WIDTH, 16, operand and sum width in bits (>=1)
CHUNK, 4, bits added per clock; must satisfy 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0, otherwise elaboration fails via $fatal
NCHUNK (localparam), WIDTH/CHUNK, number of add cycles per operation

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, ci are valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
ci  input  1  carry-in
out_valid  output  1  sum and co are valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  registered result, low WIDTH bits of a+b+ci
co  output  1  registered carry-out, bit WIDTH of a+b+ci

Behaviour:
- Reset is asynchronous: on rst_n low, all state clears immediately. Values: state IDLE, in_ready 1, out_valid 0, sum 0, co 0, chunk counter 0, internal carry 0.
- IDLE (in_ready=1): on an edge with in_valid&&in_ready, latch a, b, ci into internal operand registers. Clear the chunk counter, go to BUSY, in_ready goes 0.
- BUSY (in_ready=0, out_valid=0): each edge processes chunk i = counter.
  - {carry, acc[i*CHUNK +: CHUNK]} = a_r[i*CHUNK +: CHUNK] + b_r[i*CHUNK +: CHUNK] + carry.
  - carry is initialised to ci_r; the counter increments each edge.
  - On the edge processing chunk NCHUNK-1: load sum <= final acc, co <= final carry, out_valid <= 1, go to DONE.
- Latency: if operands are accepted at edge 0, out_valid is high after edge NCHUNK. Example: WIDTH=16, CHUNK=4 gives 4 cycles. CHUNK=WIDTH gives a single BUSY cycle.
- sum and co change only when entering DONE. They hold their value through DONE and IDLE until the next result; partial chunks are never visible on the outputs.
- DONE (out_valid=1, in_ready=0): hold sum and co stable. On the edge with out_ready=1, go to IDLE with out_valid 0 and in_ready 1.
- No overlap: a new operation can be accepted no earlier than the edge after the output handshake. Throughput is 1 result per NCHUNK+2 cycles with out_ready tied high.
- in_valid while in_ready=0 is ignored; a, b and ci are not sampled.
- out_ready outside DONE is ignored.
- Reset mid-operation (BUSY or DONE) abandons the operation and returns all outputs to their reset values. No result is produced for the abandoned operands.
- Arithmetic is modulo 2^WIDTH with carry-out. Invariant: {co,sum} == a+b+ci (WIDTH+1-bit compare).

Optional Feature:
Macro ADDER_OVF_EN.
- Defined: adds output port ovf (output, 1 bit), registered with sum. ovf = (a_r[WIDTH-1]==b_r[WIDTH-1]) && (sum[WIDTH-1]!=a_r[WIDTH-1]), i.e. two's-complement signed overflow.
  - Reset value 0.
  - Valid only with out_valid; held like sum.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: assert rst_n low asynchronously mid-cycle -> in_ready=1, out_valid=0, sum=0, co=0 immediately, before the next clk edge.
2. WIDTH=16, CHUNK=4, out_ready=1: a=16'hFFFF, b=16'h0001, ci=0 -> sum=16'h0000, co=1. out_valid rises exactly 4 edges after the accept edge and is high for 1 cycle.
3. Inter-chunk carry: a=16'h0FFF, b=16'h0000, ci=1 -> sum=16'h1000, co=0. Then a=16'h1234, b=16'h4321, ci=0 -> sum=16'h5555, co=0.
4. Backpressure:
   - Hold out_ready=0 for 10 cycles after out_valid -> out_valid, sum and co are stable and in_ready stays 0.
   - in_valid pulses carrying a=16'hAAAA during this window are not accepted.
   - After out_ready=1 -> IDLE, and in_ready=1 on the next cycle.
5. Reset mid-BUSY: pull rst_n low on the 2nd BUSY cycle -> out_valid never rises for that operation. After release, a=16'h0003, b=16'h0004, ci=0 completes with sum=16'h0007.
6. Exhaustive WIDTH=4, CHUNK=1 (all 512 a,b,ci combinations) and WIDTH=4, CHUNK=4 -> {co,sum}==a+b+ci every time. With ADDER_OVF_EN and WIDTH=16: 16'h7FFF+16'h0001 -> ovf=1; 16'h8000+16'h8000 -> ovf=1, co=1; 16'h0001+16'hFFFF -> ovf=0.
